burst_ram_arbiter: RTL and testbench
====================================

Name: burst_ram_arbiter

Overview:
- Shares one burst RAM controller port between two cache masters, m0 and m1 (for example an instruction cache and a data cache).
- Enforces the global command delay interval, so interleaved masters never violate the PSRAM command spacing.
- Holds each grant for the whole 4-beat burst.
- Sits between the caches' br_* side and the PSRAM IP.

Parameters:
BURST_RAM_DEPTH_BITWIDTH, 21, address width of an 8-byte burst RAM word
COMMAND_DELAY_INTERVAL, 13, cycles between two br_cmd_en pulses, counted from the cycle after issue
BURST_BEAT_COUNT, 4, 64-bit beats per burst (read or write)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
mN_req  in  1  (N=0,1) master holds high with cmd/addr/beat0 stable until mN_ack
mN_cmd  in  1  0 read, 1 write
mN_addr  in  BURST_RAM_DEPTH_BITWIDTH  burst start address
mN_wr_data  in  64  write beat; beat0 valid with req, beats 1..3 on the 3 cycles starting at ack
mN_ack  out  1  one-cycle pulse: command issued to RAM
mN_rd_data  out  64  br_rd_data broadcast
mN_rd_data_valid  out  1  br_rd_data_valid gated to the read owner
br_cmd  out  1  0 read, 1 write
br_cmd_en  out  1  one-cycle command strobe
br_addr  out  BURST_RAM_DEPTH_BITWIDTH  command address
br_wr_data  out  64  write beat to RAM
br_data_mask  out  8  always 0 (no masking)
br_rd_data  in  64  read data
br_rd_data_valid  in  1  read data valid

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; all outputs 0; delay counter 0; beat counter 0.
  - Round-robin pointer favours m0.
  - An in-flight burst is abandoned; no further br_cmd_en until rst is high and the counter reaches 0.
- Delay counter:
  - Loaded with COMMAND_DELAY_INTERVAL on every issue.
  - Decrements every cycle while nonzero; saturates at 0.
- IDLE:
  - Eligible when counter==0 and at least one req is high.
  - Winner: single requester, else the master not granted last (round robin).
  - Issue at the next edge, all registered: br_cmd_en=1, br_cmd/br_addr/br_wr_data from the winner's cmd/addr/wr_data; winner's ack=1.
  - Owner and pointer updated at the same edge.
  - Next state: WRITE if cmd=1, else READ_WAIT.
- WRITE:
  - br_cmd_en=0 and ack=0 on the first cycle.
  - Each cycle, br_wr_data <= owner's wr_data, for BURST_BEAT_COUNT-1 cycles.
  - Then IDLE.
  - Beats reach RAM on consecutive cycles after the command.
- READ_WAIT:
  - br_cmd_en=0.
  - Owner's rd_data_valid = br_rd_data_valid, combinational; the non-owner's valid is 0.
  - Beat counter counts valid beats; after BURST_BEAT_COUNT beats, return to IDLE.
  - Valid beats need not be contiguous.
- br_rd_data_valid outside READ_WAIT: ignored, routed to nobody.
- Requests arriving mid-burst or while counter!=0 simply wait, and are never dropped.
- Simultaneous requests: exactly one ack.
- Back-to-back requests from one master, with the other idle: granted every COMMAND_DELAY_INTERVAL+1 cycles at best.
- A master that drops req before ack: request withdrawn, nothing issued.
- Starvation-free: with both masters requesting continuously, grants strictly alternate.
- Latency, idle and counter==0: req high at edge k gives ack and br_cmd_en high after edge k.

Optional Feature:
- Macro BR_ARB_FIXED_PRIORITY_EN.
- Defined: m0 always wins simultaneous requests; the round-robin pointer is removed (m1 can starve).
- Undefined: round robin as described.
- Everything else is identical.

Test Plan:
- m0 read, addr 0x00100: br_cmd_en for 1 cycle with br_cmd=0 and br_addr=0x00100. Feed 4 valid beats 0x11..0x44: only m0_rd_data_valid pulses 4 times; state returns to IDLE.
- m1 write, addr 0x1FFFC, beats 0xA0..0xA3: br_wr_data shows A0, A1, A2, A3 on 4 consecutive cycles starting with the br_cmd_en cycle; m1_ack is a single pulse.
- m0 and m1 both req after reset: m0 is acked first. m1's br_cmd_en follows exactly 14 cycles after m0's, after m0's read completes. Repeat: m1 first, m0 second.
- m0 issues 3 back-to-back reads: consecutive br_cmd_en pulses are spaced 14 cycles apart; no command occurs while the counter is nonzero.
- rst low during READ_WAIT after 2 beats: all outputs 0 immediately. After release and with the counter at 0, a new m1 request is served normally; stale valid beats are routed to nobody.
- With BR_ARB_FIXED_PRIORITY_EN and m0/m1 requesting continuously: all acks go to m0.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
// Shares one burst RAM command port between two cache masters (m0, m1).
// Every command reloads a global delay counter so that commands from
// interleaved masters keep the RAM's minimum command spacing. A grant is
// held for the complete burst: write beats are streamed from the owner,
// and read beats are routed back to the owner only.
//
// Optional build macro: BR_ARB_FIXED_PRIORITY_EN
//   defined   -> m0 always wins simultaneous requests (no round-robin pointer)
//   undefined -> round robin between the two masters
//
// State table:
//   ST_IDLE      | wait for delay counter == 0 and a request, then issue
//   ST_WRITE     | forward write beats 1..BURST_BEAT_COUNT-1 from the owner
//   ST_READ_WAIT | route read beats to the owner until a full burst is seen

module burst_ram_arbiter #(
    parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
    parameter int COMMAND_DELAY_INTERVAL   = 13,
    parameter int BURST_BEAT_COUNT         = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,

    input  logic                                m0_req_i,
    input  logic                                m0_cmd_i,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] m0_addr_i,
    input  logic [63:0]                         m0_wr_data_i,
    output logic                                m0_ack_o,
    output logic [63:0]                         m0_rd_data_o,
    output logic                                m0_rd_data_valid_o,

    input  logic                                m1_req_i,
    input  logic                                m1_cmd_i,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] m1_addr_i,
    input  logic [63:0]                         m1_wr_data_i,
    output logic                                m1_ack_o,
    output logic [63:0]                         m1_rd_data_o,
    output logic                                m1_rd_data_valid_o,

    output logic                                br_cmd_o,
    output logic                                br_cmd_en_o,
    output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr_o,
    output logic [63:0]                         br_wr_data_o,
    output logic [7:0]                          br_data_mask_o,
    input  logic [63:0]                         br_rd_data_i,
    input  logic                                br_rd_data_valid_i
);

    localparam int AW     = BURST_RAM_DEPTH_BITWIDTH;
    localparam int CNT_W  = $clog2(COMMAND_DELAY_INTERVAL + 1);
    localparam int BEAT_W = (BURST_BEAT_COUNT > 2) ? $clog2(BURST_BEAT_COUNT) : 1;

    localparam logic [CNT_W-1:0]  DLY_LOAD = CNT_W'(COMMAND_DELAY_INTERVAL);
    localparam logic [CNT_W-1:0]  DLY_ONE  = CNT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    // Read bursts end on the last valid beat; write bursts end after the
    // beats that follow beat 0 (beat 0 travels with the command itself).
    localparam logic [BEAT_W-1:0] RD_LAST  = BEAT_W'(BURST_BEAT_COUNT - 1);
    localparam logic [BEAT_W-1:0] WR_LAST  = BEAT_W'(BURST_BEAT_COUNT - 2);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  dly_cnt_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic              owner_q;
    logic              br_cmd_en_q;
    logic              br_cmd_q;
    logic [AW-1:0]     br_addr_q;
    logic [63:0]       br_wr_data_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
`ifndef BR_ARB_FIXED_PRIORITY_EN
    // Master granted most recently; reset value 1 makes m0 win the first tie.
    logic              last_q;
`endif

    logic              issue_d;
    logic              win_d;
    logic              sel_cmd_d;
    logic [AW-1:0]     sel_addr_d;
    logic [63:0]       sel_wr_data_d;
    logic [63:0]       own_wr_data_d;

    // Arbitration: pick the winner and decide whether a command issues at the next edge.
    always_comb begin
        win_d = 1'b0;
`ifdef BR_ARB_FIXED_PRIORITY_EN
        win_d = ~m0_req_i;
`else
        if (m0_req_i && m1_req_i) begin
            win_d = ~last_q;
        end else begin
            win_d = ~m0_req_i;
        end
`endif
        issue_d       = (state_q == ST_IDLE) && (dly_cnt_q == '0) && (m0_req_i || m1_req_i);
        sel_cmd_d     = win_d ? m1_cmd_i     : m0_cmd_i;
        sel_addr_d    = win_d ? m1_addr_i    : m0_addr_i;
        sel_wr_data_d = win_d ? m1_wr_data_i : m0_wr_data_i;
        own_wr_data_d = owner_q ? m1_wr_data_i : m0_wr_data_i;
    end

    // Sequencer: delay counter, burst tracking and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            dly_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            owner_q      <= 1'b0;
            br_cmd_en_q  <= 1'b0;
            br_cmd_q     <= 1'b0;
            br_addr_q    <= '0;
            br_wr_data_q <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
`ifndef BR_ARB_FIXED_PRIORITY_EN
            last_q       <= 1'b1;
`endif
        end else begin
            br_cmd_en_q <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            if (dly_cnt_q != '0) begin
                dly_cnt_q <= dly_cnt_q - DLY_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (issue_d) begin
                        br_cmd_en_q  <= 1'b1;
                        br_cmd_q     <= sel_cmd_d;
                        br_addr_q    <= sel_addr_d;
                        br_wr_data_q <= sel_wr_data_d;
                        m0_ack_q     <= ~win_d;
                        m1_ack_q     <= win_d;
                        owner_q      <= win_d;
`ifndef BR_ARB_FIXED_PRIORITY_EN
                        last_q       <= win_d;
`endif
                        dly_cnt_q    <= DLY_LOAD;
                        beat_cnt_q   <= '0;
                        state_q      <= sel_cmd_d ? ST_WRITE : ST_READ_WAIT;
                    end
                end

                ST_WRITE: begin
                    br_wr_data_q <= own_wr_data_d;
                    if (beat_cnt_q == WR_LAST) begin
                        beat_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                    end
                end

                ST_READ_WAIT: begin
                    if (br_rd_data_valid_i) begin
                        if (beat_cnt_q == RD_LAST) begin
                            beat_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign br_cmd_en_o    = br_cmd_en_q;
    assign br_cmd_o       = br_cmd_q;
    assign br_addr_o      = br_addr_q;
    assign br_wr_data_o   = br_wr_data_q;
    assign br_data_mask_o = 8'h00;
    assign m0_ack_o       = m0_ack_q;
    assign m1_ack_o       = m1_ack_q;

    // Read data is broadcast; only the valid strobe selects the receiver.
    // Valids outside a read burst reach nobody.
    assign m0_rd_data_o       = br_rd_data_i;
    assign m1_rd_data_o       = br_rd_data_i;
    assign m0_rd_data_valid_o = br_rd_data_valid_i && (state_q == ST_READ_WAIT) && !owner_q;
    assign m1_rd_data_valid_o = br_rd_data_valid_i && (state_q == ST_READ_WAIT) &&  owner_q;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Testbench for burst_ram_arbiter: directed vector table plus hand-written
// multi-cycle sequences (arbitration order, command spacing, reset mid-burst).
module tb_burst_ram_arbiter;

    localparam int AW = 21;
    localparam logic [AW-1:0] RA0 = 21'h00200;
    localparam logic [AW-1:0] RA1 = 21'h00300;

    // Control expectation bits: {br_cmd_en, m0_ack, m1_ack, m0_valid, m1_valid}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_ISS0 = 5'b11000;
    localparam logic [4:0] C_ISS1 = 5'b10100;
    localparam logic [4:0] C_V0   = 5'b00010;
    localparam logic [4:0] C_V1   = 5'b00001;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_cmd, m1_req, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [63:0]   m0_wr_data, m1_wr_data;
    logic          m0_ack, m1_ack;
    logic [63:0]   m0_rd_data, m1_rd_data;
    logic          m0_rd_data_valid, m1_rd_data_valid;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [63:0]   br_wr_data;
    logic [7:0]    br_data_mask;
    logic [63:0]   br_rd_data;
    logic          br_rd_data_valid;

    int n_checks = 0;
    int n_err    = 0;
    int g_who[$];
    int g_cyc[$];

    typedef struct {
        int            gap;
        int            rep;
        logic          req0, cmd0, req1, cmd1;
        logic [AW-1:0] addr0, addr1;
        logic [63:0]   wd0, wd1;
        logic          rdv;
        logic [63:0]   rdd;
        logic [4:0]    e_ctl;
        logic          chk_bus;
        logic          e_cmd;
        logic [AW-1:0] e_addr;
        logic [63:0]   e_wr;
    } vec_t;

    vec_t vecs[$];

    burst_ram_arbiter dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .m0_req_i           (m0_req),
        .m0_cmd_i           (m0_cmd),
        .m0_addr_i          (m0_addr),
        .m0_wr_data_i       (m0_wr_data),
        .m0_ack_o           (m0_ack),
        .m0_rd_data_o       (m0_rd_data),
        .m0_rd_data_valid_o (m0_rd_data_valid),
        .m1_req_i           (m1_req),
        .m1_cmd_i           (m1_cmd),
        .m1_addr_i          (m1_addr),
        .m1_wr_data_i       (m1_wr_data),
        .m1_ack_o           (m1_ack),
        .m1_rd_data_o       (m1_rd_data),
        .m1_rd_data_valid_o (m1_rd_data_valid),
        .br_cmd_o           (br_cmd),
        .br_cmd_en_o        (br_cmd_en),
        .br_addr_o          (br_addr),
        .br_wr_data_o       (br_wr_data),
        .br_data_mask_o     (br_data_mask),
        .br_rd_data_i       (br_rd_data),
        .br_rd_data_valid_i (br_rd_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_cmd = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_cmd = 1'b0; m1_addr = '0; m1_wr_data = '0;
        br_rd_data = '0; br_rd_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, 128'({br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask,
                        m0_ack, m1_ack, m0_rd_data_valid, m1_rd_data_valid}), 128'(0));
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk_reset_outs("reset_outputs");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.gap = 0; v.rep = 1;
        v.req0 = 1'b0; v.cmd0 = 1'b0; v.req1 = 1'b0; v.cmd1 = 1'b0;
        v.addr0 = '0; v.addr1 = '0; v.wd0 = '0; v.wd1 = '0;
        v.rdv = 1'b0; v.rdd = '0;
        v.e_ctl = C_NONE; v.chk_bus = 1'b0; v.e_cmd = 1'b0; v.e_addr = '0; v.e_wr = '0;
        return v;
    endfunction

    // Free-running two-master model: each pending master holds req until acked
    // (or keeps requesting when keepN), and the bench returns 4 read beats for
    // every grant, checking that each beat reaches only the granted master.
    task automatic run_masters(input int ncyc, input bit p0, input bit p1,
                               input bit keep0, input bit keep1);
        bit pend0 = p0;
        bit pend1 = p1;
        bit own   = 1'b0;
        bit drv;
        int beats = 0;
        int wait_c = 0;
        g_who.delete();
        g_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            m0_req = pend0; m0_cmd = 1'b0; m0_addr = RA0;
            m1_req = pend1; m1_cmd = 1'b0; m1_addr = RA1;
            drv = 1'b0;
            if (beats > 0) begin
                if (wait_c > 0) wait_c--;
                else begin
                    drv = 1'b1;
                    beats--;
                end
            end
            br_rd_data_valid = drv;
            br_rd_data       = drv ? {32'hBEEF_0000, c} : 64'h0;
            @(negedge clk);
            chk("valid_route", 128'({m0_rd_data_valid, m1_rd_data_valid}),
                128'({drv && (own == 1'b0), drv && (own == 1'b1)}));
            if (br_cmd_en) begin
                chk("one_ack", 128'(m0_ack ^ m1_ack), 128'(1));
                chk("ack_to_requester", 128'(m1_ack ? pend1 : pend0), 128'(1));
                chk("grant_addr", 128'({br_cmd, br_addr}), 128'({1'b0, m1_ack ? RA1 : RA0}));
                g_who.push_back(int'(m1_ack));
                g_cyc.push_back(c);
                own    = m1_ack;
                beats  = 4;
                wait_c = 1;
                if (!m1_ack && !keep0) pend0 = 1'b0;
                if ( m1_ack && !keep1) pend1 = 1'b0;
            end else begin
                chk("no_ack_without_cmd", 128'({m0_ack, m1_ack}), 128'(0));
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        // --- m0 read at 0x00100 with a gap between beats, then a stray beat
        v = blank(); v.req0 = 1'b1; v.addr0 = 21'h00100;                    vecs.push_back(v);
        v = blank(); v.e_ctl = C_ISS0; v.chk_bus = 1'b1; v.e_addr = 21'h00100; vecs.push_back(v);
        v = blank(); v.rdv = 1'b1; v.rdd = 64'h11; v.e_ctl = C_V0;          vecs.push_back(v);
        v = blank();                                                        vecs.push_back(v);
        v = blank(); v.rdv = 1'b1; v.rdd = 64'h22; v.e_ctl = C_V0;          vecs.push_back(v);
        v = blank(); v.rdv = 1'b1; v.rdd = 64'h33; v.e_ctl = C_V0;          vecs.push_back(v);
        v = blank(); v.rdv = 1'b1; v.rdd = 64'h44; v.e_ctl = C_V0;          vecs.push_back(v);
        v = blank(); v.rdv = 1'b1; v.rdd = 64'h55; v.chk_bus = 1'b1; v.e_addr = 21'h00100; vecs.push_back(v);

        // --- m1 write at 0x1FFFC, beats A0..A3
        v = blank(); v.gap = 16; v.req1 = 1'b1; v.cmd1 = 1'b1; v.addr1 = 21'h1FFFC; v.wd1 = 64'hA0; vecs.push_back(v);
        v = blank(); v.wd1 = 64'hA1; v.e_ctl = C_ISS1; v.chk_bus = 1'b1; v.e_cmd = 1'b1; v.e_addr = 21'h1FFFC; v.e_wr = 64'hA0; vecs.push_back(v);
        v = blank(); v.wd1 = 64'hA2; v.chk_bus = 1'b1; v.e_cmd = 1'b1; v.e_addr = 21'h1FFFC; v.e_wr = 64'hA1; vecs.push_back(v);
        v = blank(); v.wd1 = 64'hA3; v.chk_bus = 1'b1; v.e_cmd = 1'b1; v.e_addr = 21'h1FFFC; v.e_wr = 64'hA2; vecs.push_back(v);
        v = blank();                 v.chk_bus = 1'b1; v.e_cmd = 1'b1; v.e_addr = 21'h1FFFC; v.e_wr = 64'hA3; vecs.push_back(v);
        // m0 request while the delay counter is still running: held off, not dropped
        v = blank(); v.rep = 10; v.req0 = 1'b1; v.addr0 = 21'h0ABCD; v.wd0 = 64'h77; v.wd1 = 64'h5555;
        v.chk_bus = 1'b1; v.e_cmd = 1'b1; v.e_addr = 21'h1FFFC; v.e_wr = 64'hA3; vecs.push_back(v);
        v = blank(); v.e_ctl = C_ISS0; v.chk_bus = 1'b1; v.e_addr = 21'h0ABCD; v.e_wr = 64'h77; vecs.push_back(v);
        v = blank(); v.rdv = 1'b1; v.rdd = 64'h66; v.e_ctl = C_V0; v.rep = 4; vecs.push_back(v);

        foreach (vecs[i]) begin
            if (vecs[i].gap > 0) idle(vecs[i].gap);
            for (int r = 0; r < vecs[i].rep; r++) begin
                m0_req = vecs[i].req0; m0_cmd = vecs[i].cmd0; m0_addr = vecs[i].addr0; m0_wr_data = vecs[i].wd0;
                m1_req = vecs[i].req1; m1_cmd = vecs[i].cmd1; m1_addr = vecs[i].addr1; m1_wr_data = vecs[i].wd1;
                br_rd_data_valid = vecs[i].rdv; br_rd_data = vecs[i].rdd;
                @(negedge clk);
                chk($sformatf("vec%0d_ctl", i),
                    128'({br_cmd_en, m0_ack, m1_ack, m0_rd_data_valid, m1_rd_data_valid}), 128'(vecs[i].e_ctl));
                if (vecs[i].chk_bus)
                    chk($sformatf("vec%0d_bus", i), 128'({br_cmd, br_addr, br_wr_data}),
                        128'({vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_wr}));
                if (vecs[i].rdv)
                    chk($sformatf("vec%0d_rd_data", i), {m0_rd_data, m1_rd_data}, {vecs[i].rdd, vecs[i].rdd});
                tick();
            end
        end
        idle(20);

        // --- simultaneous requests after reset: m0 first, m1 exactly 14 cycles later
        do_reset();
        run_masters(25, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("tie_grant_count", 128'(g_who.size()), 128'(2));
        if (g_who.size() == 2) begin
            chk("tie_first_m0", 128'(g_who[0]), 128'(0));
            chk("tie_second_m1", 128'(g_who[1]), 128'(1));
            chk("tie_first_latency", 128'(g_cyc[0]), 128'(1));
            chk("tie_spacing", 128'(g_cyc[1] - g_cyc[0]), 128'(14));
        end

        // --- after a lone m0 grant, the next tie goes to m1 (round robin)
        run_masters(20, 1'b1, 1'b0, 1'b0, 1'b0);
        run_masters(25, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("tie2_grant_count", 128'(g_who.size()), 128'(2));
        if (g_who.size() == 2) begin
`ifdef BR_ARB_FIXED_PRIORITY_EN
            chk("tie2_first", 128'(g_who[0]), 128'(0));
`else
            chk("tie2_first", 128'(g_who[0]), 128'(1));
`endif
            chk("tie2_second_other", 128'(g_who[1] != g_who[0]), 128'(1));
            chk("tie2_spacing", 128'(g_cyc[1] - g_cyc[0]), 128'(14));
        end

        // --- three back-to-back m0 reads, m1 idle
        idle(16);
        run_masters(40, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("b2b_grant_count", 128'(g_who.size()), 128'(3));
        for (int i = 1; i < g_cyc.size(); i++) begin
            chk("b2b_spacing", 128'(g_cyc[i] - g_cyc[i-1]), 128'(14));
            chk("b2b_owner", 128'(g_who[i]), 128'(0));
        end

        // --- both masters requesting continuously
        idle(16);
        run_masters(65, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("cont_grant_count", 128'(g_who.size()), 128'(5));
        for (int i = 1; i < g_who.size(); i++) begin
`ifdef BR_ARB_FIXED_PRIORITY_EN
            chk("cont_fixed_m0", 128'(g_who[i]), 128'(0));
`else
            chk("cont_alternate", 128'(g_who[i] != g_who[i-1]), 128'(1));
`endif
            chk("cont_spacing", 128'(g_cyc[i] - g_cyc[i-1]), 128'(14));
        end

        // --- m1 withdraws its request before the counter expires: nothing issued
        idle(16);
        run_masters(8, 1'b1, 1'b0, 1'b0, 1'b0);
        m1_req = 1'b1; m1_cmd = 1'b1; m1_addr = RA1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("withdraw_wait", 128'({br_cmd_en, m1_ack}), 128'(0));
            tick();
        end
        run_masters(20, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("withdraw_no_grant", 128'(g_who.size()), 128'(0));

        // --- reset during a read burst after two beats
        idle(4);
        m0_req = 1'b1; m0_cmd = 1'b0; m0_addr = RA0;
        @(negedge clk);
        chk("rst_seq_pre", 128'({br_cmd_en, m0_ack, m1_ack}), 128'(0));
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("rst_seq_issue", 128'({br_cmd_en, m0_ack, m1_ack, br_addr}), 128'({3'b110, RA0}));
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            br_rd_data_valid = 1'b1; br_rd_data = 64'hC0 + 64'(i);
            @(negedge clk);
            chk("rst_seq_beat", 128'({m0_rd_data_valid, m1_rd_data_valid}), 128'(2'b10));
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outs("reset_mid_burst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stale_beat_routed_nowhere", 128'({m0_rd_data_valid, m1_rd_data_valid}), 128'(0));
            tick();
        end
        run_masters(10, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_reset_grant_count", 128'(g_who.size()), 128'(1));
        if (g_who.size() == 1) begin
            chk("post_reset_m1", 128'(g_who[0]), 128'(1));
            chk("post_reset_latency", 128'(g_cyc[0]), 128'(1));
        end

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
